sid_table_sequencer: RTL
========================

SID_TABLE_SEQUENCER -- requirements
Module: sid_table_sequencer

Interface
REQ-001 Parameter NUM_VOICES, default 3, number of voices sharing one waveform-combination table (legal 1..8).
REQ-002 Parameter TBL_LAT, default 2, clock cycles from tbl_saw/tbl_tri register update to valid tbl_* data (legal 1..4).
REQ-003 Port clk  in  1  system clock; the only clock.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port ce_1m  in  1  one-cycle 1 MHz strobe that starts a sequence.
REQ-006 Port saw_in  in  12*NUM_VOICES  per-voice sawtooth value; voice i in bits [12i+11:12i].
REQ-007 Port tri_in  in  12*NUM_VOICES  per-voice triangle value, same packing.
REQ-008 Port tbl_saw  out  12  registered sawtooth address to the shared table.
REQ-009 Port tbl_tri  out  12  registered triangle address to the shared table.
REQ-010 Port tbl_st, tbl_pt, tbl_ps, tbl_pst  in  8 each  table outputs (_st, p_t, ps_, pst).
REQ-011 Port st_out, pt_out, ps_out, pst_out  out  8*NUM_VOICES each  captured per-voice results, same packing.
REQ-012 Port busy  out  1  sequence in progress.
REQ-013 Port done  out  1  one-cycle pulse: all voices captured.
REQ-014 Port overrun  out  1  sticky: ce_1m arrived while busy.
REQ-015 Port ovr_clr  in  1  clears overrun.

Function
REQ-016 States IDLE, RUN; cycle 0 = cycle in which ce_1m is high.
REQ-017 IDLE + ce_1m -> RUN; busy = 1 from cycle 1.
REQ-018 In cycle k (k = 1..NUM_VOICES), tbl_saw/tbl_tri load saw_in/tri_in of voice k-1; new value visible from cycle k+1.
REQ-019 tbl_saw/tbl_tri hold their last value outside load cycles.
REQ-020 Table data for voice k-1 is sampled at the end of cycle k+TBL_LAT into that voice's four output fields; visible from cycle k+TBL_LAT+1.
REQ-021 Output fields of a voice change only at its capture edge; they hold between sequences.
REQ-022 done = 1 in cycle NUM_VOICES+TBL_LAT+1 only; busy falls to 0 in that same cycle; state returns to IDLE.
REQ-023 Total sequence length NUM_VOICES+TBL_LAT+1 cycles; it must be shorter than the ce_1m period (assumption on the clock ratio, not checked).
REQ-024 ce_1m while busy = 1: abort the sequence, set overrun, restart at cycle 0 with voice 0; pending captures are discarded, already-captured voices keep their new values.
REQ-025 ce_1m in the done cycle: no overrun; the new sequence starts normally.
REQ-026 ovr_clr and a new overrun event in the same cycle: overrun = 1 (set wins).
REQ-027 Internal counter width is clog2(NUM_VOICES+TBL_LAT+2); the counter never wraps within a sequence.
REQ-028 Capture uses a TBL_LAT-deep valid/index shift pipeline, not a comparator, so one voice is captured per cycle.

Reset
REQ-029 reset has priority over all inputs, including ce_1m.
REQ-030 On reset: state IDLE; busy, done and overrun = 0; tbl_saw, tbl_tri and all output fields = 0; pipeline valids = 0.
REQ-031 Reset mid-sequence: the pending capture does not occur; outputs remain 0 until the next full sequence.

Structure
REQ-032 A shared package sid_pkg holds the widths SID_WAVE_W = 12 and SID_TBL_W = 8 and the state enum.
REQ-033 The block contains no table; sid_tables is instantiated beside it by the SID top.
REQ-034 One sub-module is natural: sid_seq_pipe (parametrised valid/index delay line of depth TBL_LAT).

Verification
REQ-035 Bench uses a TBL_LAT-cycle table model returning {saw[7:0]^tri[7:0]} on all four outputs.
REQ-036 NUM_VOICES = 3, TBL_LAT = 2, saw = {0x111, 0x222, 0x333}, tri = 0, ce at cycle 0 -> tbl_saw = 0x111/0x222/0x333 in cycles 2/3/4; st_out = {0x33, 0x22, 0x11} at cycle 6; done in cycle 6 only.
REQ-037 ce_1m again at cycle 4 -> overrun = 1, voice 0 recaptured at cycle 8, voices 1-2 keep the old values until cycles 9-10, done at cycle 10.
REQ-038 ce_1m in the done cycle -> overrun stays 0, second done 6 cycles later.
REQ-039 reset asserted at cycle 3 -> all outputs 0 from cycle 4; no capture at cycle 4 or 5; busy = 0.
REQ-040 NUM_VOICES = 8, TBL_LAT = 4, random inputs over 1000 ce periods of 16 cycles -> every field matches the model; overrun never set; ovr_clr with a simultaneous overrun -> overrun stays 1.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared widths and sequencer state encoding for the SID waveform-table path.
// Imported by the table sequencer and its capture pipeline.
package sid_pkg;

  localparam int SID_WAVE_W = 12;
  localparam int SID_TBL_W  = 8;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  // Voice index width, kept at least one bit so a single-voice build still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sid_seq_pipe.sv
// Valid/index delay line that tracks which voice each in-flight table lookup belongs to.
// A flush drops every in-flight entry so an aborted sequence leaves nothing behind.
module sid_seq_pipe
  import sid_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    valid_d    = valid_q;
    idx_d      = idx_q;
    valid_d[0] = in_valid & ~flush;
    idx_d[0]   = in_idx;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1] & ~flush;
      idx_d[i]   = idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/sid_table_sequencer.sv
// Time-multiplexes one waveform-combination table across NUM_VOICES voices per 1 MHz tick:
// presents each voice's saw/tri address in turn and captures the table results per voice.
module sid_table_sequencer
  import sid_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int TBL_LAT    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ce_1m,
  input  logic [SID_WAVE_W*NUM_VOICES-1:0] saw_in,
  input  logic [SID_WAVE_W*NUM_VOICES-1:0] tri_in,
  output logic [SID_WAVE_W-1:0]           tbl_saw,
  output logic [SID_WAVE_W-1:0]           tbl_tri,
  input  logic [SID_TBL_W-1:0]            tbl_st,
  input  logic [SID_TBL_W-1:0]            tbl_pt,
  input  logic [SID_TBL_W-1:0]            tbl_ps,
  input  logic [SID_TBL_W-1:0]            tbl_pst,
  output logic [SID_TBL_W*NUM_VOICES-1:0]  st_out,
  output logic [SID_TBL_W*NUM_VOICES-1:0]  pt_out,
  output logic [SID_TBL_W*NUM_VOICES-1:0]  ps_out,
  output logic [SID_TBL_W*NUM_VOICES-1:0]  pst_out,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun,
  input  logic                            ovr_clr
);

  localparam int SEQ_LEN = NUM_VOICES + TBL_LAT + 1;
  localparam int CNT_W   = $clog2(SEQ_LEN + 1);
  localparam int IDX_W   = idx_width(NUM_VOICES);
  localparam int FLD_W   = SID_TBL_W * NUM_VOICES;

  localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(SEQ_LEN);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(NUM_VOICES);
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(1);

  seq_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SID_WAVE_W-1:0]    tbl_saw_q, tbl_saw_d;
  logic [SID_WAVE_W-1:0]    tbl_tri_q, tbl_tri_d;
  logic                     overrun_q, overrun_d;
  logic [FLD_W-1:0]         st_q, st_d;
  logic [FLD_W-1:0]         pt_q, pt_d;
  logic [FLD_W-1:0]         ps_q, ps_d;
  logic [FLD_W-1:0]         pst_q, pst_d;

  logic                     in_run;
  logic                     done_cyc;
  logic                     busy_c;
  logic                     abort;
  logic                     load;
  logic [IDX_W-1:0]         load_idx;
  logic                     pipe_valid;
  logic [IDX_W-1:0]         pipe_idx;
  logic                     cap_en;

  // The done cycle is not busy, so a tick landing there starts cleanly without an overrun.
  always_comb begin
    in_run   = (state_q == SEQ_RUN);
    done_cyc = in_run && (cnt_q == DONE_CNT);
    busy_c   = in_run && !done_cyc;
    abort    = ce_1m && busy_c;
    load     = busy_c && !ce_1m && (cnt_q >= FIRST_CNT) && (cnt_q <= LAST_LOAD);
    load_idx = IDX_W'(cnt_q - FIRST_CNT);
    cap_en   = pipe_valid && !abort;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ce_1m) begin
      state_d = SEQ_RUN;
      cnt_d   = FIRST_CNT;
    end else if (done_cyc) begin
      state_d = SEQ_IDLE;
      cnt_d   = '0;
    end else if (in_run) begin
      cnt_d   = cnt_q + FIRST_CNT;
    end
  end

  always_comb begin
    tbl_saw_d = tbl_saw_q;
    tbl_tri_d = tbl_tri_q;
    if (load) begin
      tbl_saw_d = saw_in[load_idx*SID_WAVE_W +: SID_WAVE_W];
      tbl_tri_d = tri_in[load_idx*SID_WAVE_W +: SID_WAVE_W];
    end
  end

  // A new overrun event takes precedence over a clear arriving in the same cycle.
  always_comb begin
    overrun_d = abort | (overrun_q & ~ovr_clr);
  end

  always_comb begin
    st_d  = st_q;
    pt_d  = pt_q;
    ps_d  = ps_q;
    pst_d = pst_q;
    if (cap_en) begin
      st_d[pipe_idx*SID_TBL_W +: SID_TBL_W]  = tbl_st;
      pt_d[pipe_idx*SID_TBL_W +: SID_TBL_W]  = tbl_pt;
      ps_d[pipe_idx*SID_TBL_W +: SID_TBL_W]  = tbl_ps;
      pst_d[pipe_idx*SID_TBL_W +: SID_TBL_W] = tbl_pst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEQ_IDLE;
      cnt_q     <= '0;
      tbl_saw_q <= '0;
      tbl_tri_q <= '0;
      overrun_q <= 1'b0;
      st_q      <= '0;
      pt_q      <= '0;
      ps_q      <= '0;
      pst_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tbl_saw_q <= tbl_saw_d;
      tbl_tri_q <= tbl_tri_d;
      overrun_q <= overrun_d;
      st_q      <= st_d;
      pt_q      <= pt_d;
      ps_q      <= ps_d;
      pst_q     <= pst_d;
    end
  end

  // Lookups still in flight when a sequence is aborted belong to stale addresses, so flush them.
  sid_seq_pipe #(
    .DEPTH (TBL_LAT),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .in_valid  (load),
    .in_idx    (load_idx),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  assign tbl_saw = tbl_saw_q;
  assign tbl_tri = tbl_tri_q;
  assign st_out  = st_q;
  assign pt_out  = pt_q;
  assign ps_out  = ps_q;
  assign pst_out = pst_q;
  assign busy    = busy_c;
  assign done    = done_cyc;
  assign overrun = overrun_q;

endmodule
